// File: rtl/qrisc32_avalon_mem.sv
// qrisc32_avalon_mem
// Avalon responder memory shared by the three qrisc32 master ports
// (instruction read, data read, data write). A single word-addressed array
// is time-shared through a small IDLE -> [WAIT] -> DONE sequencer.
//
// Parameters
//   ADDR_W      word-address width, array holds 2**ADDR_W 32-bit words
//   WAIT_STATES extra cycles between grant and completion (0..15)
//   INIT_FILE   optional memory image name
//
// Ports
//   clk, areset                      clock, asynchronous active-low reset
//   avs_instructions_addr/rd         instruction read request (byte address)
//   avs_instructions_data/wait_req   instruction read data / wait request
//   avs_datar_addr/rd                data read request (byte address)
//   avs_datar_data/wait_req          data read data / wait request
//   avs_dataw_addr/data/wr           data write request (byte address)
//   avs_dataw_wait_req               data write wait request
//   o_dbg_state                      current sequencer state (IDLE/WAIT/DONE)
//   o_dbg_grant                      current grant (NONE/INS/DR/DW)
//
// Handshake: a master raises rd/wr with a stable address (and write data)
// and holds them while its wait_req is 1. wait_req is 1 for every port at
// all times except for the granted port during the single DONE cycle; that
// low cycle marks completion, and read data is valid in that same cycle.
// wait_req is decoded from registered state/grant only, so there is no
// combinational path from rd/wr to wait_req.
module qrisc32_avalon_mem #(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] avs_instructions_addr,
  input  logic        avs_instructions_rd,
  output logic [31:0] avs_instructions_data,
  output logic        avs_instructions_wait_req,
  input  logic [31:0] avs_datar_addr,
  input  logic        avs_datar_rd,
  output logic [31:0] avs_datar_data,
  output logic        avs_datar_wait_req,
  input  logic [31:0] avs_dataw_addr,
  input  logic [31:0] avs_dataw_data,
  input  logic        avs_dataw_wr,
  output logic        avs_dataw_wait_req,
  output logic [1:0]  o_dbg_state,
  output logic [1:0]  o_dbg_grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_INS  = 2'd1;
  localparam logic [1:0] G_DR   = 2'd2;
  localparam logic [1:0] G_DW   = 2'd3;

  localparam int DEPTH = 1 << ADDR_W;

  // With zero wait states the grant edge is also the edge entering DONE.
  localparam logic [3:0] LP_CNT_LOAD     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] LP_AFTER_GRANT  = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;

  logic [31:0]       r_mem [0:DEPTH-1];
  logic [1:0]        r_state;
  logic [1:0]        r_grant;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_ins_idx;
  logic [ADDR_W-1:0] w_dr_idx;
  logic [ADDR_W-1:0] w_dw_idx;
  logic [1:0]        w_next_grant;
  logic [ADDR_W-1:0] w_next_idx;
  logic              w_req_any;
  logic              w_dw_commit;
  logic              w_unused_bits;

  // Byte addresses are reduced to word indices; upper bits alias.
  assign w_ins_idx = avs_instructions_addr[ADDR_W+1:2];
  assign w_dr_idx  = avs_datar_addr[ADDR_W+1:2];
  assign w_dw_idx  = avs_dataw_addr[ADDR_W+1:2];

  assign w_unused_bits = ^{avs_instructions_addr[31:ADDR_W+2], avs_instructions_addr[1:0],
                           avs_datar_addr[31:ADDR_W+2], avs_datar_addr[1:0],
                           avs_dataw_addr[31:ADDR_W+2], avs_dataw_addr[1:0]};

  // Fixed priority DW > DR > INS.
  always_comb begin
    w_next_grant = G_NONE;
    w_next_idx   = w_ins_idx;
    if (avs_dataw_wr) begin
      w_next_grant = G_DW;
      w_next_idx   = w_dw_idx;
    end else if (avs_datar_rd) begin
      w_next_grant = G_DR;
      w_next_idx   = w_dr_idx;
    end else if (avs_instructions_rd) begin
      w_next_grant = G_INS;
      w_next_idx   = w_ins_idx;
    end
  end

  assign w_req_any   = (w_next_grant != G_NONE);
  // The write is committed on the grant edge, so a master that drops wr
  // before DONE still has its data stored.
  assign w_dw_commit = (r_state == ST_IDLE) && avs_dataw_wr;

  // Array contents are deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_dw_commit) r_mem[w_dw_idx] <= avs_dataw_data;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state <= ST_IDLE;
      r_grant <= G_NONE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant <= w_next_grant;
            r_idx   <= w_next_idx;
            r_cnt   <= LP_CNT_LOAD;
            r_state <= LP_AFTER_GRANT;
            // Going straight to DONE: read from the index being latched.
            if (WAIT_STATES == 0 && w_next_grant != G_DW)
              r_rdata <= r_mem[w_next_idx];
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            if (r_grant != G_DW) r_rdata <= r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_grant <= G_NONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= G_NONE;
        end
      endcase
    end
  end

  assign avs_instructions_wait_req = !((r_state == ST_DONE) && (r_grant == G_INS));
  assign avs_datar_wait_req        = !((r_state == ST_DONE) && (r_grant == G_DR));
  assign avs_dataw_wait_req        = !((r_state == ST_DONE) && (r_grant == G_DW));

  // rdata is shared; it only changes when a read completes.
  assign avs_instructions_data = r_rdata;
  assign avs_datar_data        = r_rdata;

  assign o_dbg_state = r_state;
  assign o_dbg_grant = r_grant;

endmodule

// File: tb/tb_qrisc32_avalon_mem.sv
// Directed bench for qrisc32_avalon_mem. Three instances cover the
// parameter corners: u0 (ADDR_W=10, WAIT_STATES=0), u1 (ADDR_W=10,
// WAIT_STATES=3) and u2 (ADDR_W=4, WAIT_STATES=2). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_qrisc32_avalon_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst     [3];
  logic [31:0] ins_addr [3];
  logic        ins_rd   [3];
  logic [31:0] ins_data [3];
  logic        ins_wait [3];
  logic [31:0] dr_addr  [3];
  logic        dr_rd    [3];
  logic [31:0] dr_data  [3];
  logic        dr_wait  [3];
  logic [31:0] dw_addr  [3];
  logic [31:0] dw_data  [3];
  logic        dw_wr    [3];
  logic        dw_wait  [3];
  logic [1:0]  dbg_st   [3];
  logic [1:0]  dbg_gr   [3];

  int passed = 0;
  int total  = 0;

  qrisc32_avalon_mem #(.ADDR_W(10), .WAIT_STATES(0)) u0 (
    .clk(clk), .areset(arst[0]),
    .avs_instructions_addr(ins_addr[0]), .avs_instructions_rd(ins_rd[0]),
    .avs_instructions_data(ins_data[0]), .avs_instructions_wait_req(ins_wait[0]),
    .avs_datar_addr(dr_addr[0]), .avs_datar_rd(dr_rd[0]),
    .avs_datar_data(dr_data[0]), .avs_datar_wait_req(dr_wait[0]),
    .avs_dataw_addr(dw_addr[0]), .avs_dataw_data(dw_data[0]),
    .avs_dataw_wr(dw_wr[0]), .avs_dataw_wait_req(dw_wait[0]),
    .o_dbg_state(dbg_st[0]), .o_dbg_grant(dbg_gr[0])
  );

  qrisc32_avalon_mem #(.ADDR_W(10), .WAIT_STATES(3)) u1 (
    .clk(clk), .areset(arst[1]),
    .avs_instructions_addr(ins_addr[1]), .avs_instructions_rd(ins_rd[1]),
    .avs_instructions_data(ins_data[1]), .avs_instructions_wait_req(ins_wait[1]),
    .avs_datar_addr(dr_addr[1]), .avs_datar_rd(dr_rd[1]),
    .avs_datar_data(dr_data[1]), .avs_datar_wait_req(dr_wait[1]),
    .avs_dataw_addr(dw_addr[1]), .avs_dataw_data(dw_data[1]),
    .avs_dataw_wr(dw_wr[1]), .avs_dataw_wait_req(dw_wait[1]),
    .o_dbg_state(dbg_st[1]), .o_dbg_grant(dbg_gr[1])
  );

  qrisc32_avalon_mem #(.ADDR_W(4), .WAIT_STATES(2)) u2 (
    .clk(clk), .areset(arst[2]),
    .avs_instructions_addr(ins_addr[2]), .avs_instructions_rd(ins_rd[2]),
    .avs_instructions_data(ins_data[2]), .avs_instructions_wait_req(ins_wait[2]),
    .avs_datar_addr(dr_addr[2]), .avs_datar_rd(dr_rd[2]),
    .avs_datar_data(dr_data[2]), .avs_datar_wait_req(dr_wait[2]),
    .avs_dataw_addr(dw_addr[2]), .avs_dataw_data(dw_data[2]),
    .avs_dataw_wr(dw_wr[2]), .avs_dataw_wait_req(dw_wait[2]),
    .o_dbg_state(dbg_st[2]), .o_dbg_grant(dbg_gr[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  // kind: 0 = instruction read, 1 = data read, 2 = data write
  function automatic logic wait_of(input int d, input int kind);
    return (kind == 0) ? ins_wait[d] : ((kind == 1) ? dr_wait[d] : dw_wait[d]);
  endfunction

  function automatic logic [31:0] waits_of(input int d);
    return 32'({dw_wait[d], dr_wait[d], ins_wait[d]});
  endfunction

  task automatic set_req(input int d, input int kind, input logic val,
                         input logic [31:0] addr, input logic [31:0] wdata);
    case (kind)
      0: begin ins_addr[d] = addr; ins_rd[d] = val; end
      1: begin dr_addr[d] = addr; dr_rd[d] = val; end
      default: begin dw_addr[d] = addr; dw_data[d] = wdata; dw_wr[d] = val; end
    endcase
  endtask

  // Called on a falling edge with the DUT idle. Runs one transfer, checks
  // its latency and that completion lasts one cycle; returns read data.
  task automatic xfer(input string tag, input int d, input int kind,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd_val);
    int n;
    n = 0;
    set_req(d, kind, 1'b1, addr, wdata);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (wait_of(d, kind) == 1'b0) begin
        n = i;
        break;
      end
    end
    rd_val = (kind == 0) ? ins_data[d] : dr_data[d];
    set_req(d, kind, 1'b0, addr, wdata);
    chk($sformatf("%s_latency", tag), 32'(n), 32'(1 + ws_of(d)));
    @(negedge clk);
    chk($sformatf("%s_one_cycle", tag), 32'(wait_of(d, kind)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] v;
  logic [31:0] exp_waits [5];
  int n;

  initial begin
    for (int d = 0; d < 3; d++) begin
      arst[d] = 1'b0;
      ins_addr[d] = '0; ins_rd[d] = 1'b0;
      dr_addr[d] = '0;  dr_rd[d] = 1'b0;
      dw_addr[d] = '0;  dw_data[d] = '0; dw_wr[d] = 1'b0;
    end

    // Reset held for three cycles, then released.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rst_waits_u%0d_c%0d", d, c), waits_of(d), 32'h7);
        chk($sformatf("rst_drdata_u%0d_c%0d", d, c), dr_data[d], 32'h0);
        chk($sformatf("rst_insdata_u%0d_c%0d", d, c), ins_data[d], 32'h0);
      end
    end
    for (int d = 0; d < 3; d++) arst[d] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_waits_u%0d", d), waits_of(d), 32'h7);
      chk($sformatf("post_rst_drdata_u%0d", d), dr_data[d], 32'h0);
      chk($sformatf("post_rst_insdata_u%0d", d), ins_data[d], 32'h0);
      chk($sformatf("post_rst_state_u%0d", d), 32'(dbg_st[d]), 32'h0);
      chk($sformatf("post_rst_grant_u%0d", d), 32'(dbg_gr[d]), 32'h0);
    end

    // u0: single write then read, zero wait states.
    xfer("u0_w10", 0, 2, 32'h10, 32'hDEADBEEF, v);
    xfer("u0_r10", 0, 1, 32'h10, 32'h0, v);
    chk("u0_r10_data", v, 32'hDEADBEEF);

    // A write must not disturb the shared read-data register.
    xfer("u0_w00", 0, 2, 32'h0, 32'hCAFEF00D, v);
    chk("u0_rdata_hold_dr", dr_data[0], 32'hDEADBEEF);
    chk("u0_rdata_hold_ins", ins_data[0], 32'hDEADBEEF);

    // u0: all three masters at once; completions DW, DR, INS two cycles apart.
    exp_waits[0] = 32'h3;  // {dw,dr,ins} = 011: DW completes
    exp_waits[1] = 32'h7;
    exp_waits[2] = 32'h5;  // 101: DR completes
    exp_waits[3] = 32'h7;
    exp_waits[4] = 32'h6;  // 110: INS completes
    set_req(0, 2, 1'b1, 32'h20, 32'h12345678);
    set_req(0, 1, 1'b1, 32'h20, 32'h0);
    set_req(0, 0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("u0_simul_waits_k%0d", k + 1), waits_of(0), exp_waits[k]);
      if (k == 0) set_req(0, 2, 1'b0, 32'h20, 32'h12345678);
      if (k == 2) begin
        chk("u0_simul_dr_data", dr_data[0], 32'h12345678);
        set_req(0, 1, 1'b0, 32'h20, 32'h0);
      end
      if (k == 4) begin
        chk("u0_simul_ins_data", ins_data[0], 32'hCAFEF00D);
        set_req(0, 0, 1'b0, 32'h0, 32'h0);
      end
    end
    @(negedge clk);
    chk("u0_simul_idle_waits", waits_of(0), 32'h7);

    // u1: three wait states.
    xfer("u1_w04", 1, 2, 32'h4, 32'h0BADF00D, v);
    xfer("u1_ins04", 1, 0, 32'h4, 32'h0, v);
    chk("u1_ins04_data", v, 32'h0BADF00D);
    xfer("u1_ins07", 1, 0, 32'h7, 32'h0, v);
    chk("u1_ins07_lowbits_ignored", v, 32'h0BADF00D);

    // u1: master drops rd right after the grant; the read still completes.
    xfer("u1_w08", 1, 2, 32'h8, 32'h5A5A0001, v);
    set_req(1, 1, 1'b1, 32'h8, 32'h0);
    @(negedge clk);
    chk("u1_drop_state_wait", 32'(dbg_st[1]), 32'h1);
    set_req(1, 1, 1'b0, 32'h8, 32'h0);
    n = 0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (dr_wait[1] == 1'b0) begin
        n = i;
        break;
      end
    end
    chk("u1_drop_latency", 32'(n), 32'd4);
    chk("u1_drop_data", dr_data[1], 32'h5A5A0001);
    @(negedge clk);

    // u2: ADDR_W=4 wrap-around, two wait states.
    xfer("u2_w40", 2, 2, 32'h40, 32'hA5A5A5A5, v);
    xfer("u2_r00", 2, 1, 32'h0, 32'h0, v);
    chk("u2_r00_wrap", v, 32'hA5A5A5A5);
    xfer("u2_ins43", 2, 0, 32'h43, 32'h0, v);
    chk("u2_ins43_wrap", v, 32'hA5A5A5A5);
    xfer("u2_w08", 2, 2, 32'h8, 32'h11112222, v);

    // u2: reset asserted while a read sits in WAIT.
    set_req(2, 1, 1'b1, 32'h8, 32'h0);
    @(negedge clk);
    chk("u2_midrst_in_wait", 32'(dbg_st[2]), 32'h1);
    chk("u2_midrst_waits_pre", waits_of(2), 32'h7);
    #1;
    arst[2] = 1'b0;
    set_req(2, 1, 1'b0, 32'h8, 32'h0);
    #1;
    chk("u2_midrst_async_idle", 32'(dbg_st[2]), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("u2_midrst_waits_c%0d", c), waits_of(2), 32'h7);
      chk($sformatf("u2_midrst_data_c%0d", c), dr_data[2], 32'h0);
    end
    arst[2] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("u2_after_rst_waits_c%0d", c), waits_of(2), 32'h7);
    end
    xfer("u2_r08_fresh", 2, 1, 32'h8, 32'h0, v);
    chk("u2_r08_intact", v, 32'h11112222);
    xfer("u2_r00_fresh", 2, 1, 32'h0, 32'h0, v);
    chk("u2_r00_intact", v, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
